// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue sequencer:
// opcodes, write-source codes, FSM states, decode.
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_XOR     = 4'd3,
    OP_OR      = 4'd4,
    OP_SHL     = 4'd5,
    OP_SHR     = 4'd6,
    OP_ADDI    = 4'd7,
    OP_MOVTO   = 4'd8,
    OP_MOVFROM = 4'd9,
    OP_LDR     = 4'd10,
    OP_STR     = 4'd11,
    OP_BEQ     = 4'd12,
    OP_BNE     = 4'd13,
    OP_NOP     = 4'd14,
    OP_HALT    = 4'd15
  } opcode_e;

  localparam logic [1:0] WRSRC_ALU = 2'd0;
  localparam logic [1:0] WRSRC_MEM = 2'd1;
  localparam logic [1:0] WRSRC_RDB = 2'd2;
  localparam logic [1:0] WRSRC_RDA = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       wr;
    logic [2:0] waddr;
    logic [1:0] wsrc;
    logic       req;
    logic       store;
  } dec_t;

  // Control bundle loaded into the EXEC output registers.
  function automatic dec_t decode(
    input logic [3:0] opc,
    input logic [2:0] rb
  );
    dec_t    d;
    opcode_e op;
    op = opcode_e'(opc);
    d  = '0;
    unique case (1'b1)
      (op <= OP_ADDI): begin
        d.op   = opc;
        d.wr   = 1'b1;
        d.wsrc = WRSRC_ALU;
      end
      (op == OP_MOVTO): begin
        d.wr    = 1'b1;
        d.waddr = rb;
        d.wsrc  = WRSRC_RDA;
      end
      (op == OP_MOVFROM): begin
        d.wr   = 1'b1;
        d.wsrc = WRSRC_RDB;
      end
      (op == OP_LDR): begin
        d.req  = 1'b1;
        d.wsrc = WRSRC_MEM;
      end
      (op == OP_STR): begin
        d.req   = 1'b1;
        d.store = 1'b1;
      end
      (op == OP_BEQ) || (op == OP_BNE): begin
        d.op = OP_SUB;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_branch_lut.sv
// Branch target table: eight fixed PC targets
// selected by the Rb field of a BEQ/BNE.
module alu_issue_ctrl_branch_lut
  import alu_issue_ctrl_pkg::*;
#(
  parameter int PW = 10
) (
  input  logic [2:0]    sel,
  output logic [PW-1:0] target
);

  // Pure lookup, no state.
  always_comb begin
    target = '0;
    unique case (sel)
      3'd0: target = PW'(10'h000);
      3'd1: target = PW'(10'h020);
      3'd2: target = PW'(10'h040);
      3'd3: target = PW'(10'h080);
      3'd4: target = PW'(10'h100);
      3'd5: target = PW'(10'h200);
      3'd6: target = PW'(10'h3F0);
      3'd7: target = PW'(10'h3FF);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer between a synchronous
// instruction ROM and the ALU / register file.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int PW = 10,
  parameter int IW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Done,
  output logic [PW-1:0] ProgCtr,
  input  logic [IW-1:0] InstIn,
  output logic [3:0]    Operand,
  output logic [4:0]    Immediate,
  output logic [2:0]    RegAddrA,
  output logic [2:0]    RegAddrB,
  output logic          RegWrEn,
  output logic [2:0]    RegWrAddr,
  output logic [1:0]    WrSrc,
  output logic          MemReq,
  output logic          MemWrite,
  input  logic          MemAck,
  input  logic          Zero,
  input  logic          Equal
);

  state_e        state;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_nxt;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] target;
  logic [IW-1:0] ir;
  logic          wr_q;
  opcode_e       op;
  dec_t          dec;
  logic          is_mem;
  logic          is_halt;
  logic          br_taken;
  logic          ld_ack;

  alu_issue_ctrl_branch_lut #(
    .PW(PW)
  ) branch_lut (
    .sel   (ir[4:2]),
    .target(target)
  );

  // Instruction field decode and flag evaluation.
  always_comb begin
    op       = opcode_e'(ir[8:5]);
    dec      = decode(InstIn[8:5], InstIn[4:2]);
    is_mem   = (op == OP_LDR) || (op == OP_STR);
    is_halt  = (op == OP_HALT);
    br_taken = ((op == OP_BEQ) && Equal)
            || ((op == OP_BNE) && !Zero);
    ld_ack   = (state == ST_MEM) && MemAck && !MemWrite;
    pc_inc   = pc + PW'(1);
  end

  // Next PC; the ROM address leads the PC register by
  // one cycle so the word is ready when FETCH ends.
  always_comb begin
    pc_nxt = pc;
    unique case (state)
      ST_IDLE, ST_HALTED: begin
        if (Start) pc_nxt = '0;
      end
      ST_EXEC: begin
        if (br_taken) pc_nxt = target;
        else if (!is_mem && !is_halt) pc_nxt = pc_inc;
      end
      ST_MEM: begin
        if (MemAck) pc_nxt = pc_inc;
      end
      default: pc_nxt = pc;
    endcase
  end

  // Load writeback fires in the ack cycle itself.
  always_comb begin
    ProgCtr   = pc_nxt;
    Immediate = ir[4:0];
    RegAddrA  = '0;
    RegAddrB  = ir[4:2];
    RegWrEn   = wr_q || ld_ack;
  end

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      Done      <= 1'b0;
      Operand   <= '0;
      wr_q      <= 1'b0;
      RegWrAddr <= '0;
      WrSrc     <= '0;
      MemReq    <= 1'b0;
      MemWrite  <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      wr_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (Start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          state     <= ST_EXEC;
          ir        <= InstIn;
          Operand   <= dec.op;
          wr_q      <= dec.wr;
          RegWrAddr <= dec.waddr;
          WrSrc     <= dec.wsrc;
          MemReq    <= dec.req;
          MemWrite  <= dec.store;
        end
        ST_EXEC: begin
          if (is_mem) begin
            state <= ST_MEM;
          end else if (is_halt) begin
            state <= ST_HALTED;
            Done  <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (MemAck) begin
            state    <= ST_FETCH;
            MemReq   <= 1'b0;
            MemWrite <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (Start) begin
            state <= ST_FETCH;
            Done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a
// register-write scoreboard and a ROM model.
module tb_alu_issue_ctrl;

  localparam int PW = 10;
  localparam int IW = 9;

  localparam logic [8:0] I_NOP  = 9'h1C0;
  localparam logic [8:0] I_HALT = 9'h1E0;

  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] src;
  } wr_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Done;
  logic [PW-1:0] ProgCtr;
  logic [IW-1:0] InstIn;
  logic [3:0]    Operand;
  logic [4:0]    Immediate;
  logic [2:0]    RegAddrA;
  logic [2:0]    RegAddrB;
  logic          RegWrEn;
  logic [2:0]    RegWrAddr;
  logic [1:0]    WrSrc;
  logic          MemReq;
  logic          MemWrite;
  logic          MemAck;
  logic          Zero;
  logic          Equal;

  logic [8:0] rom [0:1023];
  wr_t        sb [$];
  int         checks = 0;
  int         errors = 0;
  logic       wr_prev = 1'b0;

  alu_issue_ctrl #(.PW(PW), .IW(IW)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Done     (Done),
    .ProgCtr  (ProgCtr),
    .InstIn   (InstIn),
    .Operand  (Operand),
    .Immediate(Immediate),
    .RegAddrA (RegAddrA),
    .RegAddrB (RegAddrB),
    .RegWrEn  (RegWrEn),
    .RegWrAddr(RegWrAddr),
    .WrSrc    (WrSrc),
    .MemReq   (MemReq),
    .MemWrite (MemWrite),
    .MemAck   (MemAck),
    .Zero     (Zero),
    .Equal    (Equal)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: one cycle read latency.
  always @(posedge Clk) InstIn <= rom[ProgCtr];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic start_exec();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (Done) break;
      cyc();
    end
    chk(tag, 32'(Done), 32'd1);
  endtask

  task automatic run_branch(
    input string      tag,
    input logic [8:0] inst,
    input logic       eq,
    input logic       zr,
    input logic [9:0] exp_pc
  );
    rom[0] = inst;
    rom[1] = I_HALT;
    Equal  = eq;
    Zero   = zr;
    start_exec();
    chk({tag, "_op"}, 32'(Operand), 32'd1);
    chk({tag, "_wr"}, 32'(RegWrEn), 32'd0);
    chk({tag, "_pc"}, 32'(ProgCtr), 32'(exp_pc));
    cyc();
    chk({tag, "_fetch"}, 32'(ProgCtr), 32'(exp_pc));
    wait_done({tag, "_done"}, 10);
  endtask

  // Register-write monitor, sampled late in each cycle.
  always begin
    @(negedge Clk);
    #3;
    if (RegWrEn) begin
      chk("wr_consec", 32'(wr_prev), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_write", 32'({RegWrAddr, WrSrc}), 32'(e));
      end
    end
    wr_prev = RegWrEn;
  end

  initial begin
    int done_n;
    logic wrap;
    logic [PW-1:0] prev_pc;
    Reset  = 1'b1;
    Start  = 1'b0;
    MemAck = 1'b0;
    Zero   = 1'b0;
    Equal  = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    rom[0]     = 9'h0E5;
    rom[1]     = I_HALT;
    rom[10'h020] = I_HALT;
    rom[10'h3FF] = I_HALT;
    cyc();
    cyc();
    Reset = 1'b0;

    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_wren", 32'(RegWrEn), 32'd0);
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_wr", 32'(MemWrite), 32'd0);
    chk("rst_op", 32'(Operand), 32'd0);
    chk("rst_pc", 32'(ProgCtr), 32'd0);

    // ADDI 5 then HALT
    sb.push_back('{addr: 3'd0, src: 2'd0});
    Start = 1'b1;
    cyc();
    chk("addi_fetch_pc", 32'(ProgCtr), 32'd0);
    Start = 1'b0;
    cyc();
    chk("addi_op", 32'(Operand), 32'd7);
    chk("addi_imm", 32'(Immediate), 32'd5);
    chk("addi_wren", 32'(RegWrEn), 32'd1);
    chk("addi_pc", 32'(ProgCtr), 32'd1);
    cyc();
    chk("addi_wren_off", 32'(RegWrEn), 32'd0);
    chk("halt_fetch_pc", 32'(ProgCtr), 32'd1);
    cyc();
    chk("halt_exec_done", 32'(Done), 32'd0);
    cyc();
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_pc", 32'(ProgCtr), 32'd1);

    // Branches
    run_branch("beq_t", 9'h184, 1'b1, 1'b0, 10'h020);
    run_branch("beq_n", 9'h184, 1'b0, 1'b1, 10'h001);
    run_branch("bne_t", 9'h1A4, 1'b1, 1'b0, 10'h020);
    run_branch("bne_n", 9'h1A4, 1'b0, 1'b1, 10'h001);
    run_branch("beq_r7", 9'h19C, 1'b1, 1'b1, 10'h3FF);
    run_branch("bne_r7", 9'h1BC, 1'b0, 1'b0, 10'h3FF);
    Equal = 1'b0;
    Zero  = 1'b0;

    // LDR with ack on the fourth request cycle
    rom[0] = 9'h148;
    sb.push_back('{addr: 3'd0, src: 2'd1});
    start_exec();
    chk("ldr_req", 32'(MemReq), 32'd1);
    chk("ldr_wr", 32'(MemWrite), 32'd0);
    chk("ldr_wren", 32'(RegWrEn), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("ldr_hold_req", 32'(MemReq), 32'd1);
      chk("ldr_hold_wr", 32'(MemWrite), 32'd0);
      chk("ldr_hold_wren", 32'(RegWrEn), 32'd0);
      chk("ldr_hold_pc", 32'(ProgCtr), 32'd0);
    end
    cyc();
    MemAck = 1'b1;
    #1;
    chk("ldr_ack_req", 32'(MemReq), 32'd1);
    chk("ldr_ack_wren", 32'(RegWrEn), 32'd1);
    chk("ldr_ack_src", 32'(WrSrc), 32'd1);
    chk("ldr_ack_pc", 32'(ProgCtr), 32'd1);
    cyc();
    MemAck = 1'b0;
    chk("ldr_req_off", 32'(MemReq), 32'd0);
    chk("ldr_wren_off", 32'(RegWrEn), 32'd0);
    chk("ldr_next_pc", 32'(ProgCtr), 32'd1);
    wait_done("ldr_done", 10);

    // STR with ack after one cycle
    rom[0] = 9'h168;
    start_exec();
    chk("str_req", 32'(MemReq), 32'd1);
    chk("str_wr", 32'(MemWrite), 32'd1);
    cyc();
    MemAck = 1'b1;
    #1;
    chk("str_ack_wr", 32'(MemWrite), 32'd1);
    chk("str_ack_wren", 32'(RegWrEn), 32'd0);
    chk("str_ack_pc", 32'(ProgCtr), 32'd1);
    cyc();
    MemAck = 1'b0;
    chk("str_req_off", 32'(MemReq), 32'd0);
    wait_done("str_done", 10);

    // Moves and a shift
    rom[0] = 9'h114;
    rom[1] = 9'h12C;
    rom[2] = 9'h0A3;
    rom[3] = I_NOP;
    rom[4] = I_HALT;
    sb.push_back('{addr: 3'd5, src: 2'd3});
    sb.push_back('{addr: 3'd0, src: 2'd2});
    sb.push_back('{addr: 3'd0, src: 2'd0});
    start_exec();
    chk("movto_rb", 32'(RegAddrB), 32'd5);
    chk("movto_ra", 32'(RegAddrA), 32'd0);
    cyc();
    cyc();
    chk("movfrom_rb", 32'(RegAddrB), 32'd3);
    cyc();
    cyc();
    chk("shl_op", 32'(Operand), 32'd5);
    chk("shl_imm", 32'(Immediate), 32'd3);
    wait_done("prog_done", 20);
    chk("prog_pc", 32'(ProgCtr), 32'd4);

    // Reset while waiting in MEM
    rom[0] = 9'h148;
    rom[1] = I_HALT;
    start_exec();
    cyc();
    chk("mrst_in_mem", 32'(MemReq), 32'd1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("mrst_req", 32'(MemReq), 32'd0);
    chk("mrst_wr", 32'(MemWrite), 32'd0);
    chk("mrst_wren", 32'(RegWrEn), 32'd0);
    chk("mrst_done", 32'(Done), 32'd0);
    chk("mrst_op", 32'(Operand), 32'd0);
    chk("mrst_pc", 32'(ProgCtr), 32'd0);
    MemAck = 1'b1;
    #1;
    chk("mrst_ack_wren", 32'(RegWrEn), 32'd0);
    cyc();
    MemAck = 1'b0;
    chk("mrst_ack_pc", 32'(ProgCtr), 32'd0);
    chk("mrst_ack_req", 32'(MemReq), 32'd0);

    // PC wrap across the full ROM
    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    done_n  = 0;
    wrap    = 1'b0;
    prev_pc = '0;
    Start   = 1'b1;
    for (int n = 1; n <= 2200; n++) begin
      cyc();
      if (n == 1) Start = 1'b0;
      if (n == 20) rom[1] = I_HALT;
      if (prev_pc == 10'h3FF && ProgCtr == 10'h000) wrap = 1'b1;
      prev_pc = ProgCtr;
      if (Done) begin
        done_n = n;
        break;
      end
    end
    chk("wrap_seen", 32'(wrap), 32'd1);
    chk("wrap_cycles", 32'(done_n), 32'd2053);
    chk("wrap_done", 32'(Done), 32'd1);
    chk("wrap_pc", 32'(ProgCtr), 32'd1);

    cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
